pn_seq_checker: RTL

- Receive-side counterpart of the n_bit_pn generator: takes the serial PN bit stream, self-synchronises to it and reports lock and bit errors.
- Uses the same runtime-selected degree (num) and the same characteristic polynomial word (char_poly[12:0], from blk_mem_gen_0).
- err_count is 13 bits wide, so it can drive bcd_n_bit #(13) and the seven-segment display path directly.
- Bits arrive as single-cycle strobes, such as the debounced deb_nxt pulse or a looped-back generator output.

---
 rtl/pn_pkg.sv | 13 +
 rtl/pn_predict.sv | 11 +
 rtl/pn_seq_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pn_pkg.sv
// pn_pkg: state encoding, history width and degree mask shared by the PN generator/checker pair.
package pn_pkg;
  localparam int PN_MAXN = 13;
  typedef enum logic [1:0] {
    ST_ACQ = 2'd0,
    ST_VER = 2'd1,
    ST_LCK = 2'd2,
    ST_BAD = 2'd3
  } pn_state_t;
  function automatic logic [PN_MAXN-1:0] mask_n(input logic [3:0] num);
    return ~({PN_MAXN{1'b1}} << num);
  endfunction
endpackage

// File: rtl/pn_predict.sv
// pn_predict: next PN bit as the parity of the tapped history bits within the active degree.
module pn_predict
  import pn_pkg::*;
(
  input  logic [PN_MAXN-1:0] h,
  input  logic [PN_MAXN-1:0] char_poly,
  input  logic [3:0]         num,
  output logic               p
);
  assign p = ^(h & char_poly & mask_n(num));
endmodule

// File: rtl/pn_seq_checker.sv
// pn_seq_checker: self-synchronising PN stream checker with lock detection and error counting.
module pn_seq_checker
  import pn_pkg::*;
#(
  parameter int LOCK_CNT  = 16,
  parameter int ERR_LIMIT = 4,
  parameter int WINDOW    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic [3:0]  num,
  input  logic [12:0] char_poly,
  output logic        locked,
  output logic [1:0]  state,
  output logic        err_pulse,
  output logic [12:0] err_count
);
  pn_state_t st, st_n;
  logic [PN_MAXN-1:0] h, h_n, poly_r, mask, h_rx, h_gen;
  logic [3:0] num_r, fill, fill_n;
  logic [7:0] match, match_n;
  logic [9:0] win, win_n, werr, werr_n, win_inc, werr_inc;
  logic [12:0] cnt_n;
  logic p, pulse_n, legal, cfg_chg, mis;
  assign mask     = mask_n(num_r);
  assign legal    = num >= 4'd2 && num <= 4'd13;
  assign cfg_chg  = num != num_r || char_poly != poly_r;
  assign mis      = bit_in != p;
  assign h_rx     = {h[PN_MAXN-2:0], bit_in};
  assign h_gen    = {h[PN_MAXN-2:0], p};
  assign win_inc  = win + 10'd1;
  assign werr_inc = werr + 10'(mis);
  assign state    = st;
  pn_predict u_predict (.h(h), .char_poly(poly_r), .num(num_r), .p(p));
  // Any configuration change or illegal degree restarts acquisition and drops the pending bit.
  always_comb begin
    st_n    = st;
    h_n     = h;
    fill_n  = fill;
    match_n = match;
    win_n   = win;
    werr_n  = werr;
    pulse_n = 1'b0;
    cnt_n   = err_count;
    if (st == ST_BAD || cfg_chg || !legal) begin
      st_n    = legal ? ST_ACQ : ST_BAD;
      h_n     = '0;
      fill_n  = '0;
      match_n = '0;
      win_n   = '0;
      werr_n  = '0;
    end else if (bit_valid) begin
      case (st)
        ST_ACQ: begin
          h_n    = h_rx;
          fill_n = fill + 4'd1;
          if (fill + 4'd1 == num_r) begin
            st_n    = ST_VER;
            match_n = '0;
          end
        end
        ST_VER: begin
          h_n = h_rx;
          if (mis || (h_rx & mask) == '0) begin
            st_n   = ST_ACQ;
            fill_n = '0;
          end else begin
            match_n = match + 8'd1;
            if (match + 8'd1 == 8'(LOCK_CNT)) begin
              st_n   = ST_LCK;
              win_n  = '0;
              werr_n = '0;
            end
          end
        end
        ST_LCK: begin
          pulse_n = mis;
          cnt_n   = err_count + 13'(mis && err_count != '1);
          // The local regenerator feeds back its own prediction so channel errors never reach h.
          if (werr_inc == 10'(ERR_LIMIT)) begin
            st_n   = ST_ACQ;
            fill_n = '0;
            h_n    = '0;
            win_n  = '0;
            werr_n = '0;
          end else begin
            h_n    = h_gen;
            win_n  = win_inc == 10'(WINDOW) ? '0 : win_inc;
            werr_n = win_inc == 10'(WINDOW) ? '0 : werr_inc;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    num_r  <= num;
    poly_r <= char_poly;
    if (rst) begin
      st        <= ST_ACQ;
      h         <= '0;
      fill      <= '0;
      match     <= '0;
      win       <= '0;
      werr      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      st        <= st_n;
      h         <= h_n;
      fill      <= fill_n;
      match     <= match_n;
      win       <= win_n;
      werr      <= werr_n;
      locked    <= st_n == ST_LCK;
      err_pulse <= pulse_n;
      err_count <= cnt_n;
    end
  end
endmodule
